// File: rtl/tablet_dispenser.sv
// tablet_dispenser: fill-pulse source with a bottle-swap req/ack handshake; the jam alarm is enabled by DISPENSE_JAM_EN.
// Latency: fill rises 1 cycle after start; counters and bottle_req update in the first cycle after fill falls.
// Backpressure: SWAP holds bottle_req until bottle_ack (with DISPENSE_JAM_EN, until ACK_TIMEOUT cycles have passed).
module tablet_dispenser #(
    parameter int PULSE_PERIOD = 1000,
    parameter int PULSE_WIDTH  = 100,
    parameter int CNT_W        = 10,
    parameter int ACK_TIMEOUT  = 4096
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_capacity,
    input  logic [CNT_W-1:0] i_total,
    input  logic             i_bottle_ack,
    output logic             o_fill,
    output logic             o_bottle_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_alarm,
    output logic [CNT_W-1:0] o_tablet_cnt,
    output logic [CNT_W-1:0] o_bottle_cnt
);

`ifdef DISPENSE_JAM_EN
    localparam bit JAM_EN = 1'b1;
`else
    localparam bit JAM_EN = 1'b0;
`endif

    localparam int GAP_LEN = PULSE_PERIOD - PULSE_WIDTH;
    localparam int ACK_LEN = JAM_EN ? ACK_TIMEOUT : 1;
    localparam int PH_MAX  = (PULSE_WIDTH > GAP_LEN) ? PULSE_WIDTH : GAP_LEN;
    localparam int TMR_MAX = (PH_MAX > ACK_LEN) ? PH_MAX : ACK_LEN;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] DROP_LAST = TMR_W'(PULSE_WIDTH - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_LEN - 1);
`ifdef DISPENSE_JAM_EN
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_LEN - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DROP,
        S_GAP,
        S_SWAP,
`ifdef DISPENSE_JAM_EN
        S_ALARM,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [CNT_W-1:0]  r_cap;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_disp;
    logic [CNT_W-1:0]  r_tablet_cnt;
    logic [CNT_W-1:0]  r_bottle_cnt;
    logic              r_stop_pend;
    logic              r_fill;
    logic              r_bottle_req;
    logic              r_busy;
    logic              r_done;
    logic              w_start_ok;
    logic              w_start_take;
    logic              w_drop_end;
    logic              w_ack_take;
    logic [CNT_W-1:0]  w_tab_inc;
    logic [CNT_W-1:0]  w_disp_inc;

    assign w_tab_inc  = r_tablet_cnt + 1'b1;
    assign w_disp_inc = r_disp + 1'b1;
    assign w_start_ok = i_start && !i_stop && (i_capacity != '0) && (i_total != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = '0;
        w_start_take = 1'b0;
        w_drop_end   = 1'b0;
        w_ack_take   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE
`ifdef DISPENSE_JAM_EN
            , S_ALARM
`endif
            : begin
                if (w_start_ok) begin
                    w_start_take = 1'b1;
                    w_state_nxt  = S_DROP;
                end
            end
            S_DROP: begin
                if (r_timer == DROP_LAST) begin
                    w_drop_end = 1'b1;
                    // Completion outranks a pending stop and a full bottle.
                    if (w_disp_inc == r_total)
                        w_state_nxt = S_DONE;
                    else if (r_stop_pend || i_stop)
                        w_state_nxt = S_IDLE;
                    else if (w_tab_inc == r_cap)
                        w_state_nxt = S_SWAP;
                    else
                        w_state_nxt = S_GAP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_GAP: begin
                if (i_stop)
                    w_state_nxt = S_IDLE;
                else if (r_timer == GAP_LAST)
                    w_state_nxt = S_DROP;
                else
                    w_timer_nxt = r_timer + 1'b1;
            end
            S_SWAP: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_bottle_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_GAP;
                end
`ifdef DISPENSE_JAM_EN
                else if (r_timer == ACK_LAST)
                    w_state_nxt = S_ALARM;
                else
                    w_timer_nxt = r_timer + 1'b1;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fill       <= 1'b0;
            r_bottle_req <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_fill       <= (w_state_nxt == S_DROP);
            r_bottle_req <= (w_state_nxt == S_SWAP);
            r_busy       <= (w_state_nxt == S_DROP) || (w_state_nxt == S_GAP) ||
                            (w_state_nxt == S_SWAP);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cap        <= '0;
            r_total      <= '0;
            r_disp       <= '0;
            r_tablet_cnt <= '0;
            r_bottle_cnt <= '0;
            r_stop_pend  <= 1'b0;
        end else if (w_start_take) begin
            r_cap        <= i_capacity;
            r_total      <= i_total;
            r_disp       <= '0;
            r_tablet_cnt <= '0;
            r_bottle_cnt <= '0;
            r_stop_pend  <= 1'b0;
        end else begin
            if (w_drop_end) begin
                r_tablet_cnt <= w_tab_inc;
                r_disp       <= w_disp_inc;
                r_stop_pend  <= 1'b0;
            end else if ((r_state == S_DROP) && i_stop) begin
                r_stop_pend  <= 1'b1;
            end
            if (w_ack_take) begin
                r_bottle_cnt <= r_bottle_cnt + 1'b1;
                r_tablet_cnt <= '0;
            end
        end
    end

`ifdef DISPENSE_JAM_EN
    logic r_alarm;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_alarm <= 1'b0;
        else
            r_alarm <= (w_state_nxt == S_ALARM);
    end
    assign o_alarm = r_alarm;
`else
    assign o_alarm = 1'b0;
`endif

    assign o_fill       = r_fill;
    assign o_bottle_req = r_bottle_req;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_tablet_cnt = r_tablet_cnt;
    assign o_bottle_cnt = r_bottle_cnt;

endmodule

// File: tb/tb_tablet_dispenser.sv
// Bench for tablet_dispenser: PERIOD=8, WIDTH=3; table of full runs with an auto-acking conveyor, plus directed corner cases.
module tb_tablet_dispenser;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [CW-1:0] i_capacity = '0;
    logic [CW-1:0] i_total = '0;
    logic          i_bottle_ack = 1'b0;
    logic          o_fill, o_bottle_req, o_busy, o_done, o_alarm;
    logic [CW-1:0] o_tablet_cnt, o_bottle_cnt;

    int checks = 0;
    int errors = 0;

    tablet_dispenser #(
        .PULSE_PERIOD(8), .PULSE_WIDTH(3), .CNT_W(CW), .ACK_TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_capacity(i_capacity), .i_total(i_total), .i_bottle_ack(i_bottle_ack),
        .o_fill(o_fill), .o_bottle_req(o_bottle_req), .o_busy(o_busy),
        .o_done(o_done), .o_alarm(o_alarm),
        .o_tablet_cnt(o_tablet_cnt), .o_bottle_cnt(o_bottle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cap;
        logic [CW-1:0] total;
        int            pulses;
        int            hs;
        int            tcnt;
        int            bcnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One complete run; the conveyor acks on the 2nd cycle bottle_req is seen high.
    task automatic run_vec(input int id, input vec_t v);
        int  pulses = 0, hs = 0, width = 0, idx = 0, req_cyc = 0;
        int  width_bad = 0, per_bad = 0, cnt_bad = 0, req_bad = 0, post_bad = 0;
        int  mt = 0, mb = 0, last_rise = 0, ack_idx = 0;
        bit  have_prev = 0, swapped = 0, ack_pend = 0, got_done = 0;
        int  lat_fill;
        logic pf = 1'b0, pr = 1'b0;
        i_capacity = v.cap;
        i_total    = v.total;
        i_start    = 1'b1;
        step();
        i_start  = 1'b0;
        lat_fill = int'(o_fill);
        while (!got_done && idx < 600) begin
            idx++;
            if (ack_pend) begin
                ack_pend     = 0;
                i_bottle_ack = 1'b0;
                mt = 0;
                mb++;
                if (o_bottle_req !== 1'b0) req_bad++;
            end
            if (o_fill && !pf) begin
                pulses++;
                width = 0;
                if (have_prev) begin
                    if (swapped && (idx - ack_idx != 6)) per_bad++;
                    if (!swapped && (idx - last_rise != 8)) per_bad++;
                end
                have_prev = 1;
                swapped   = 0;
                last_rise = idx;
            end
            if (o_fill) width++;
            if (!o_fill && pf) begin
                mt++;
                if (width != 3) width_bad++;
            end
            if (o_bottle_req && !pr && !(pf && !o_fill)) req_bad++;
            if (o_tablet_cnt !== CW'(mt) || o_bottle_cnt !== CW'(mb)) cnt_bad++;
            req_cyc = o_bottle_req ? req_cyc + 1 : 0;
            if (req_cyc == 2) begin
                i_bottle_ack = 1'b1;
                ack_pend = 1;
                hs++;
                swapped  = 1;
                ack_idx  = idx;
            end
            got_done = o_done;
            pf = o_fill;
            pr = o_bottle_req;
            if (!got_done) step();
        end
        check($sformatf("v%0d done", id), int'(got_done), 1);
        check($sformatf("v%0d start latency", id), lat_fill, 1);
        check($sformatf("v%0d pulses", id), pulses, v.pulses);
        check($sformatf("v%0d handshakes", id), hs, v.hs);
        check($sformatf("v%0d tablet_cnt", id), int'(o_tablet_cnt), v.tcnt);
        check($sformatf("v%0d bottle_cnt", id), int'(o_bottle_cnt), v.bcnt);
        check($sformatf("v%0d busy at done", id), int'(o_busy), 0);
        check($sformatf("v%0d width errs", id), width_bad, 0);
        check($sformatf("v%0d period errs", id), per_bad, 0);
        check($sformatf("v%0d counter errs", id), cnt_bad, 0);
        check($sformatf("v%0d req timing errs", id), req_bad, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_fill || o_bottle_req || !o_done) post_bad++;
        end
        check($sformatf("v%0d after done errs", id), post_bad, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{cap: 10'd3, total: 10'd7, pulses: 7, hs: 2, tcnt: 1, bcnt: 2};
        vecs[1] = '{cap: 10'd3, total: 10'd6, pulses: 6, hs: 1, tcnt: 3, bcnt: 1};
        vecs[2] = '{cap: 10'd1, total: 10'd3, pulses: 3, hs: 2, tcnt: 1, bcnt: 2};
        vecs[3] = '{cap: 10'd5, total: 10'd2, pulses: 2, hs: 0, tcnt: 2, bcnt: 0};
        vecs[4] = '{cap: 10'd2, total: 10'd5, pulses: 5, hs: 2, tcnt: 1, bcnt: 2};

        step();
        step();
        i_reset = 1'b0;
        step();
        check("reset outputs",
              int'({o_fill, o_bottle_req, o_busy, o_done, o_alarm}), 0);
        check("reset tablet_cnt", int'(o_tablet_cnt), 0);
        check("reset bottle_cnt", int'(o_bottle_cnt), 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Stop in the 2nd cycle of pulse 2; also a mid-run start and capacity/total changes.
        i_capacity = 3; i_total = 7; i_start = 1'b1;
        step();                               // idx1
        i_start = 1'b0;
        check("stop run first fill", int'(o_fill), 1);
        i_capacity = 1; i_total = 1;
        repeat (3) step();                    // idx4, gap
        check("latched cap no req", int'(o_bottle_req), 0);
        check("latched total no done", int'(o_done), 0);
        step();                               // idx5
        i_start = 1'b1;
        step();                               // idx6
        i_start = 1'b0;
        check("start ignored in gap", int'(o_fill), 0);
        repeat (4) step();                    // idx10
        check("2nd pulse cycle 2", int'(o_fill), 1);
        i_stop = 1'b1;
        step();                               // idx11
        i_stop = 1'b0;
        check("pulse not truncated", int'(o_fill), 1);
        step();                               // idx12
        check("stop idle fill", int'(o_fill), 0);
        check("stop idle busy", int'(o_busy), 0);
        check("stop idle done", int'(o_done), 0);
        check("stop tablet_cnt", int'(o_tablet_cnt), 2);
        repeat (6) step();
        check("stop no further pulse", int'(o_fill), 0);

        // Stop during GAP takes effect the next cycle.
        i_capacity = 3; i_total = 7; i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (4) step();                    // idx5, gap
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("gap stop busy", int'(o_busy), 0);
        check("gap stop tablet_cnt", int'(o_tablet_cnt), 1);

        // Invalid starts.
        n = 0;
        i_capacity = 0; i_total = 5; i_start = 1'b1;
        step();
        i_capacity = 5; i_total = 0;
        step();
        i_total = 5; i_stop = 1'b1;
        step();
        i_start = 1'b0; i_stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_fill || o_busy) n++;
            step();
        end
        check("invalid start activity", n, 0);

        // Asynchronous reset while in SWAP.
        i_capacity = 1; i_total = 3; i_start = 1'b1;
        step();
        i_start = 1'b0;
        n = 0;
        while (!o_bottle_req && n < 50) begin
            step();
            n++;
        end
        check("reached swap", int'(o_bottle_req), 1);
        i_reset = 1'b1;
        #1;
        check("async reset req", int'(o_bottle_req), 0);
        check("async reset fill", int'(o_fill), 0);
        check("async reset counters", int'(o_tablet_cnt) + int'(o_bottle_cnt), 0);
        step();
        i_reset = 1'b0;
        step();
        check("after reset busy", int'(o_busy), 0);

`ifdef DISPENSE_JAM_EN
        i_capacity = 1; i_total = 3; i_start = 1'b1;
        step();
        i_start = 1'b0;
        n = 0;
        while (!o_bottle_req && n < 50) begin
            step();
            n++;
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_alarm) break;
            if (o_bottle_req) n++;
            step();
        end
        check("jam req cycles", n, 16);
        check("jam alarm", int'(o_alarm), 1);
        check("jam req low", int'(o_bottle_req), 0);
        check("jam busy low", int'(o_busy), 0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("restart clears alarm", int'(o_alarm), 0);
        check("restart fill", int'(o_fill), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tablet_dispenser.md
# tablet_dispenser

Tablet feeder that produces the `fill` pulse stream consumed by the filling-machine controller and talks to the bottle conveyor with a req/ack handshake. The block emits one debounce-clean pulse per dropped tablet and requests a bottle swap each time the current bottle reaches capacity. It stops when the programmed total has been dispensed. It is the source end of the `fill` interface and doubles as a bench and board stimulus generator for the controller.

## Interface
- `PULSE_PERIOD`, default 1000: clk cycles from one `fill` rising edge to the next within a bottle.
- `PULSE_WIDTH`, default 100: clk cycles `fill` is held high. Requires 1 ≤ `PULSE_WIDTH` < `PULSE_PERIOD`.
- `CNT_W`, default 10: width of the capacity, total and counter fields.
- `ACK_TIMEOUT`, default 4096: clk cycles to wait for `bottle_ack`. Used only with `DISPENSE_JAM_EN`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `capacity`  in  CNT_W  tablets per bottle. Latched at start.
- `total`  in  CNT_W  tablets to dispense. Latched at start.
- `bottle_ack`  in  1  conveyor has placed a fresh bottle.
- `fill`  out  1  tablet-drop pulse.
- `bottle_req`  out  1  request for a bottle swap.
- `busy`  out  1  high in DROP, GAP and SWAP.
- `done`  out  1  total dispensed. Sticky.
- `alarm`  out  1  ack timeout (jam). Sticky.
- `tablet_cnt`  out  CNT_W  tablets in the current bottle.
- `bottle_cnt`  out  CNT_W  full bottles swapped out.

## Operation
- States: IDLE, DROP, GAP, SWAP, DONE, and ALARM (ALARM only with the macro).
- Reset: state IDLE. All outputs 0. All counters 0.
- IDLE/DONE/ALARM + `start`:
  - Starts only if `capacity`≠0, `total`≠0 and `stop`=0.
  - Latches `capacity` and `total`; clears counters, the dispensed count, `done` and `alarm`; goes to DROP.
  - Otherwise `start` is ignored.
- `start` in DROP, GAP or SWAP is ignored.
- DROP: `fill`=1 for exactly `PULSE_WIDTH` cycles. On the last cycle, `tablet_cnt`+1 and dispensed+1. Exit is decided in this priority order:
  - dispensed==total → DONE. Includes the case where the bottle is exactly full; no swap is requested.
  - otherwise a pending stop → IDLE.
  - otherwise `tablet_cnt`+1==capacity → SWAP.
  - otherwise → GAP.
- GAP: `fill`=0 for `PULSE_PERIOD`−`PULSE_WIDTH` cycles, then DROP.
- SWAP: `bottle_req`=1. On a cycle where `bottle_ack`=1: `bottle_cnt`+1, `tablet_cnt`←0, go to GAP.
- `bottle_ack` outside SWAP is ignored.
- `stop`:
  - In DROP: latched as pending. The current pulse is never truncated.
  - In GAP or SWAP: go to IDLE next cycle; `bottle_req` drops.
  - Counters hold their values in all cases.
- DONE: `done`=1, counters frozen.
- Arithmetic: counters are CNT_W unsigned. Compares are on the latched values, so changing `capacity` or `total` mid-run has no effect.

## Timing
- `start` sampled at edge N → `fill` high from N+1 through N+`PULSE_WIDTH`.
- Within a bottle, `fill` rising edges are exactly `PULSE_PERIOD` cycles apart.
- Counter update is visible in the first cycle after `fill` falls. `bottle_req` rises in that same cycle.
- Ack accepted at edge M → `bottle_req` low from M+1. Next `fill` rises at M+1+(`PULSE_PERIOD`−`PULSE_WIDTH`).
- `done` rises in the first cycle after the final `fill` falls.
- All outputs are registered, with no combinational input-to-output paths.
- `reset` mid-run: `fill` and `bottle_req` go low immediately (asynchronously). The run is lost.

## Configuration
- `DISPENSE_JAM_EN` defined:
  - A SWAP timer counts cycles while in SWAP.
  - If `bottle_ack` is not seen within `ACK_TIMEOUT` cycles → ALARM: `alarm`=1, `bottle_req`=0, `busy`=0.
  - Exit from ALARM only by `reset` or a valid `start`.
- Not defined:
  - SWAP waits indefinitely.
  - `alarm` is tied 0; no timer logic is present.

## Test plan
- PERIOD=8, WIDTH=3, capacity=3, total=7, ack 2 cycles after each req → 7 pulses, each 3 cycles wide. 2 handshakes. Final `tablet_cnt`=1, `bottle_cnt`=2, `done`=1.
- Same parameters, total=6 → 6 pulses. Only 1 handshake. `done` with `tablet_cnt`=3, `bottle_cnt`=1. `bottle_req` never rises after the 6th pulse.
- `stop` on the 2nd cycle of the 2nd pulse → that pulse completes its full 3 cycles. IDLE next; `tablet_cnt`=2, `busy`=0, `done`=0.
- `start` with capacity=0 or total=0 → no `fill`; `busy` stays 0.
- `reset` asserted in SWAP → `bottle_req` and `fill` go 0 immediately. All counters read 0.
- With `DISPENSE_JAM_EN` and ACK_TIMEOUT=16, no ack → `alarm`=1 after 16 SWAP cycles, `bottle_req`=0. A following `start` clears `alarm` and restarts the run.
